// File: rtl/el2_dccm_bank_array.sv
// DCCM bank array: independent single-ported synchronous SRAM banks with a 1-cycle read latency.
// After reset, a sweep writes INIT_WORD to every index before any request is accepted.
module el2_dccm_bank_array #(
    parameter int DCCM_NUM_BANKS   = 4,
    parameter int DCCM_FDATA_WIDTH = 39,
    parameter int DCCM_INDEX_BITS  = 12,
    parameter logic [DCCM_FDATA_WIDTH-1:0] INIT_WORD = '0
) (
    input  logic                                              clk,
    input  logic                                              rst_l,
    input  logic [DCCM_NUM_BANKS-1:0]                         dccm_clken,
    input  logic [DCCM_NUM_BANKS-1:0]                         dccm_wren_bank,
    input  logic [DCCM_NUM_BANKS-1:0][DCCM_INDEX_BITS-1:0]    dccm_addr_bank,
    input  logic [DCCM_NUM_BANKS-1:0][DCCM_FDATA_WIDTH-1:0]   dccm_wr_data_bank,
    output logic [DCCM_NUM_BANKS-1:0][DCCM_FDATA_WIDTH-1:0]   dccm_bank_dout,
    output logic                                              dccm_init_done
);

    localparam int NB    = DCCM_NUM_BANKS;
    localparam int W     = DCCM_FDATA_WIDTH;
    localparam int IDX   = DCCM_INDEX_BITS;
    localparam int DEPTH = 1 << IDX;
    localparam logic [IDX:0] LAST_IDX = (IDX+1)'(DEPTH - 1);

    typedef enum logic {
        INIT,
        READY
    } state_e;

    state_e         state_q, state_d;
    logic [IDX:0]   initIdx_q, initIdx_d;
    logic [IDX-1:0] sweepIdx;

    assign sweepIdx       = initIdx_q[IDX-1:0];
    assign dccm_init_done = (state_q == READY);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q   <= INIT;
            initIdx_q <= '0;
        end else begin
            state_q   <= state_d;
            initIdx_q <= initIdx_d;
        end
    end

    // The sweep index is one bit wider than an address so the terminal count never aliases index 0.
    always_comb begin
        state_d   = state_q;
        initIdx_d = initIdx_q;
        if (state_q == INIT) begin
            initIdx_d = initIdx_q + (IDX+1)'(1);
            if (initIdx_q == LAST_IDX) begin
                state_d = READY;
            end
        end
    end

    for (genvar b = 0; b < NB; b++) begin : gBank
        logic [W-1:0] mem [DEPTH];
        logic [W-1:0] bankDout_q;

        always_ff @(posedge clk) begin
            if (state_q == INIT) begin
                mem[sweepIdx] <= INIT_WORD;
            end else if (dccm_clken[b] && dccm_wren_bank[b]) begin
                mem[dccm_addr_bank[b]] <= dccm_wr_data_bank[b];
            end
        end

        // Output register only loads on a read; writes and idle cycles hold it like a real SRAM.
        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                bankDout_q <= '0;
            end else if (state_q == READY && dccm_clken[b] && !dccm_wren_bank[b]) begin
                bankDout_q <= mem[dccm_addr_bank[b]];
            end
        end

        assign dccm_bank_dout[b] = bankDout_q;
    end

    clkenKnown: assert property (@(posedge clk) disable iff (!rst_l)
        (state_q == READY) |-> !$isunknown(dccm_clken));

endmodule

// File: tb/tb_el2_dccm_bank_array.sv
// Self-checking bench for el2_dccm_bank_array: init sweep timing, bank reads/writes,
// output hold, back-to-back read-after-write and reset during init/ready.
module tb_el2_dccm_bank_array;

    localparam int NB    = 4;
    localparam int W     = 39;
    localparam int IDX   = 12;
    localparam int DEPTH = 1 << IDX;

    logic                     clk = 1'b0;
    logic                     rst_l;
    logic [NB-1:0]            clken;
    logic [NB-1:0]            wren;
    logic [NB-1:0][IDX-1:0]   addr;
    logic [NB-1:0][W-1:0]     wdata;
    logic [NB-1:0][W-1:0]     dccm_bank_dout;
    logic                     dccm_init_done;

    typedef struct {
        int           bank;
        logic [W-1:0] val;
        string        tag;
    } exp_t;

    exp_t         sbq[$];
    logic [W-1:0] model [NB][DEPTH];
    logic [W-1:0] expDout [NB];
    bit           benchReady;
    int           vectors;
    int           miscompares;

    el2_dccm_bank_array dut (
        .clk               (clk),
        .rst_l             (rst_l),
        .dccm_clken        (clken),
        .dccm_wren_bank    (wren),
        .dccm_addr_bank    (addr),
        .dccm_wr_data_bank (wdata),
        .dccm_bank_dout    (dccm_bank_dout),
        .dccm_init_done    (dccm_init_done)
    );

    always #5 clk = ~clk;

    task automatic idle();
        clken = '0;
        wren  = '0;
    endtask

    // Reference behaviour for the request currently on the pins; expectations are queued per bank.
    task automatic predictAndPush(input string tag);
        exp_t e;
        for (int b = 0; b < NB; b++) begin
            if (benchReady && clken[b]) begin
                if (wren[b]) model[b][addr[b]] = wdata[b];
                else         expDout[b] = model[b][addr[b]];
            end
            e.bank = b;
            e.val  = expDout[b];
            e.tag  = tag;
            sbq.push_back(e);
        end
    endtask

    task automatic clearBenchState();
        benchReady = 1'b0;
        for (int b = 0; b < NB; b++) expDout[b] = '0;
        sbq.delete();
    endtask

    task automatic runInitSweep(output int riseEdge, output bit doutDirty);
        riseEdge  = -1;
        doutDirty = 1'b0;
        rst_l     = 1'b1;
        for (int i = 1; i <= DEPTH + 500; i++) begin
            @(posedge clk);
            #1;
            if (dccm_bank_dout !== '0) doutDirty = 1'b1;
            if (dccm_init_done === 1'b1) begin
                riseEdge = i;
                break;
            end
        end
        idle();
        if (riseEdge > 0) begin
            benchReady = 1'b1;
            for (int b = 0; b < NB; b++) begin
                expDout[b] = '0;
                for (int i = 0; i < DEPTH; i++) model[b][i] = '0;
            end
        end
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        idle();
        addr  = '0;
        wdata = '0;
        clearBenchState();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (dccm_init_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_init_done: got %b, expected 0", dccm_init_done);
        end
        for (int b = 0; b < NB; b++) begin
            vectors++;
            if (dccm_bank_dout[b] !== '0) begin
                miscompares++;
                $display("[TB] FAIL reset_dout bank%0d: got %h, expected 0", b, dccm_bank_dout[b]);
            end
        end
    endtask

    // Traffic driven during the sweep must be ignored: bank0 tries to write idx 0, others try to read.
    task automatic test_init_sweep();
        int riseEdge;
        bit doutDirty;
        clken = '1;
        wren  = 4'b0001;
        addr  = '0;
        wdata[0] = 39'h1;
        for (int b = 1; b < NB; b++) wdata[b] = W'({$urandom(), $urandom()});
        runInitSweep(riseEdge, doutDirty);
        vectors++;
        if (riseEdge !== DEPTH) begin
            miscompares++;
            $display("[TB] FAIL init_rise_edge: got %0d, expected %0d", riseEdge, DEPTH);
        end
        vectors++;
        if (doutDirty !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL init_dout_zero: got nonzero dout, expected 0 during init");
        end
    endtask

    task automatic test_read_init_values();
        exp_t e;
        for (int cyc = 0; cyc < 3; cyc++) begin
            idle();
            if (cyc == 0) begin
                clken = 4'b1001;
                addr[0] = 12'd0;
                addr[3] = 12'd4095;
            end else begin
                clken = '1;
                for (int b = 0; b < NB; b++) addr[b] = IDX'($urandom_range(0, DEPTH - 1));
            end
            predictAndPush("init_value");
            @(posedge clk);
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                vectors++;
                if (dccm_bank_dout[e.bank] !== e.val) begin
                    miscompares++;
                    $display("[TB] FAIL %s bank%0d: got %h, expected %h", e.tag, e.bank, dccm_bank_dout[e.bank], e.val);
                end
            end
            if (cyc == 0) begin
                vectors++;
                if (dccm_bank_dout[0] !== 39'h0 || dccm_bank_dout[3] !== 39'h0) begin
                    miscompares++;
                    $display("[TB] FAIL init_read b0/b3: got %h/%h, expected 0/0", dccm_bank_dout[0], dccm_bank_dout[3]);
                end
            end
        end
        idle();
    endtask

    task automatic test_write_read();
        exp_t e;
        for (int cyc = 0; cyc < 3; cyc++) begin
            idle();
            case (cyc)
                0: begin clken[1] = 1'b1; wren[1] = 1'b1; addr[1] = 12'h123; wdata[1] = 39'h12_3456_789A; end
                1: begin clken[1] = 1'b1; addr[1] = 12'h123; end
                default: ;
            endcase
            predictAndPush("write_read");
            @(posedge clk);
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                vectors++;
                if (dccm_bank_dout[e.bank] !== e.val) begin
                    miscompares++;
                    $display("[TB] FAIL %s bank%0d: got %h, expected %h", e.tag, e.bank, dccm_bank_dout[e.bank], e.val);
                end
            end
            if (cyc >= 1) begin
                vectors++;
                if (dccm_bank_dout[1] !== 39'h12_3456_789A) begin
                    miscompares++;
                    $display("[TB] FAIL write_read_b1: got %h, expected 123456789a", dccm_bank_dout[1]);
                end
            end
        end
    endtask

    task automatic test_mixed_banks();
        exp_t e;
        for (int cyc = 0; cyc < 4; cyc++) begin
            idle();
            case (cyc)
                0: begin
                    clken = 4'b1001; wren = 4'b1001;
                    addr[0] = 12'd6; wdata[0] = 39'h0A_BCDE_F012;
                    addr[3] = 12'd7; wdata[3] = 39'h55;
                end
                1: begin clken[0] = 1'b1; addr[0] = 12'd6; end
                2: begin
                    clken = 4'b0101; wren = 4'b0001;
                    addr[0] = 12'd5; wdata[0] = 39'h7F_FFFF_FFFF;
                    addr[2] = 12'd5;
                end
                default: begin clken[0] = 1'b1; addr[0] = 12'd5; end
            endcase
            predictAndPush("mixed");
            @(posedge clk);
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                vectors++;
                if (dccm_bank_dout[e.bank] !== e.val) begin
                    miscompares++;
                    $display("[TB] FAIL %s bank%0d: got %h, expected %h", e.tag, e.bank, dccm_bank_dout[e.bank], e.val);
                end
            end
            if (cyc == 2) begin
                vectors++;
                if (dccm_bank_dout[0] !== 39'h0A_BCDE_F012 || dccm_bank_dout[2] !== 39'h0) begin
                    miscompares++;
                    $display("[TB] FAIL mixed_hold b0/b2: got %h/%h, expected abcdef012/0", dccm_bank_dout[0], dccm_bank_dout[2]);
                end
            end
            if (cyc == 3) begin
                vectors++;
                if (dccm_bank_dout[0] !== 39'h7F_FFFF_FFFF) begin
                    miscompares++;
                    $display("[TB] FAIL mixed_readback_b0: got %h, expected 7fffffffff", dccm_bank_dout[0]);
                end
            end
        end
    endtask

    task automatic test_clken_hold();
        exp_t e;
        logic [W-1:0] want;
        for (int cyc = 0; cyc < 14; cyc++) begin
            idle();
            if (cyc == 0) begin
                clken[3] = 1'b1; addr[3] = 12'd7;
            end else if (cyc <= 10) begin
                wren[3]  = 1'($urandom_range(0, 1));
                addr[3]  = (cyc % 3 == 0) ? 12'd7 : IDX'($urandom_range(0, 15));
                wdata[3] = W'({$urandom(), $urandom()});
            end else begin
                clken[3] = 1'b1; addr[3] = IDX'(cyc - 5);
            end
            predictAndPush("clken_hold");
            @(posedge clk);
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                vectors++;
                if (dccm_bank_dout[e.bank] !== e.val) begin
                    miscompares++;
                    $display("[TB] FAIL %s bank%0d: got %h, expected %h", e.tag, e.bank, dccm_bank_dout[e.bank], e.val);
                end
            end
            want = (cyc <= 10 || cyc == 12) ? 39'h55 : 39'h0;
            vectors++;
            if (dccm_bank_dout[3] !== want) begin
                miscompares++;
                $display("[TB] FAIL clken_hold_b3 cyc%0d: got %h, expected %h", cyc, dccm_bank_dout[3], want);
            end
        end
        idle();
    endtask

    // Directed write/read pairs to one index, then random mixed traffic over a small address window.
    task automatic test_back_to_back();
        exp_t e;
        for (int cyc = 0; cyc < 28; cyc++) begin
            idle();
            if (cyc < 4) begin
                clken[2] = 1'b1;
                addr[2]  = 12'd100;
                wren[2]  = (cyc % 2 == 0);
                wdata[2] = (cyc == 0) ? 39'h11_2233_4455 : 39'h66_7788_99AA;
            end else begin
                for (int b = 0; b < NB; b++) begin
                    clken[b] = 1'($urandom_range(0, 1));
                    wren[b]  = 1'($urandom_range(0, 1));
                    addr[b]  = IDX'($urandom_range(0, 7));
                    wdata[b] = W'({$urandom(), $urandom()});
                end
            end
            predictAndPush("back_to_back");
            @(posedge clk);
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                vectors++;
                if (dccm_bank_dout[e.bank] !== e.val) begin
                    miscompares++;
                    $display("[TB] FAIL %s bank%0d: got %h, expected %h", e.tag, e.bank, dccm_bank_dout[e.bank], e.val);
                end
            end
            if (cyc == 1 || cyc == 3) begin
                vectors++;
                if (dccm_bank_dout[2] !== ((cyc == 1) ? 39'h11_2233_4455 : 39'h66_7788_99AA)) begin
                    miscompares++;
                    $display("[TB] FAIL raw_b2 cyc%0d: got %h, expected %h", cyc, dccm_bank_dout[2],
                             (cyc == 1) ? 39'h11_2233_4455 : 39'h66_7788_99AA);
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int riseEdge;
        bit doutDirty;
        for (int cyc = 0; cyc < 2; cyc++) begin
            idle();
            clken[2] = 1'b1;
            wren[2]  = (cyc == 0);
            addr[2]  = 12'd9;
            wdata[2] = 39'h3C_0F0F_0F0F;
            predictAndPush("pre_reset");
            @(posedge clk);
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                vectors++;
                if (dccm_bank_dout[e.bank] !== e.val) begin
                    miscompares++;
                    $display("[TB] FAIL %s bank%0d: got %h, expected %h", e.tag, e.bank, dccm_bank_dout[e.bank], e.val);
                end
            end
        end
        idle();
        for (int phase = 0; phase < 2; phase++) begin
            rst_l = 1'b0;
            clearBenchState();
            #2;
            vectors++;
            if (dccm_init_done !== 1'b0 || dccm_bank_dout !== '0) begin
                miscompares++;
                $display("[TB] FAIL async_reset phase%0d: got done=%b dout2=%h, expected 0/0", phase, dccm_init_done, dccm_bank_dout[2]);
            end
            @(posedge clk);
            #1;
            rst_l = 1'b1;
            if (phase == 0) begin
                repeat (2000) @(posedge clk);
                #1;
                vectors++;
                if (dccm_init_done !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL mid_init_done: got %b, expected 0", dccm_init_done);
                end
            end
        end
        runInitSweep(riseEdge, doutDirty);
        vectors++;
        if (riseEdge !== DEPTH) begin
            miscompares++;
            $display("[TB] FAIL reinit_rise_edge: got %0d, expected %0d", riseEdge, DEPTH);
        end
        idle();
        clken[2] = 1'b1;
        addr[2]  = 12'd9;
        predictAndPush("post_reset");
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            vectors++;
            if (dccm_bank_dout[e.bank] !== e.val) begin
                miscompares++;
                $display("[TB] FAIL %s bank%0d: got %h, expected %h", e.tag, e.bank, dccm_bank_dout[e.bank], e.val);
            end
        end
        vectors++;
        if (dccm_bank_dout[2] !== 39'h0) begin
            miscompares++;
            $display("[TB] FAIL reinit_word_b2: got %h, expected 0", dccm_bank_dout[2]);
        end
        idle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_init_sweep();
        test_read_init_values();
        test_write_read();
        test_mixed_banks();
        test_clken_hold();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
